roundkey_seq: RTL and testbench

Round-key sequencer that sits directly downstream of the pipelined AES key expansion. It waits a fixed number of cycles after a key load for the expansion pipeline's outputs to settle. It then snapshots all NB*(NR+1) expanded words into a local round-key register file. On request, it streams one 128-bit round key per cycle to the iterative cipher/inverse-cipher core, in encryption order (0..NR) or decryption order (NR..0).

---
 rtl/roundkey_seq_if.sv | 29 ++
 rtl/roundkey_seq.sv | 128 ++++++++++++
 tb/tb_roundkey_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/roundkey_seq_if.sv
// Round-key sequencer bus: expanded key words in from the key expansion,
// one 128-bit round key per beat out to the cipher core.
interface roundkey_seq_if #(
    parameter int WORD = 32,
    parameter int NB   = 4,
    parameter int NR   = 10,
    parameter int IW   = $clog2(NR + 1)
);
    logic                         i_key_valid;
    logic [WORD*NB*(NR+1)-1:0]    i_w;
    logic                         i_rk_req;
    logic                         i_rk_dec;
    logic                         o_key_ready;
    logic                         o_busy;
    logic                         o_rk_valid;
    logic [WORD*NB-1:0]           o_rk;
    logic [IW-1:0]                o_rk_idx;
    logic                         o_rk_last;

    modport master (
        output i_key_valid, i_w, i_rk_req, i_rk_dec,
        input  o_key_ready, o_busy, o_rk_valid, o_rk, o_rk_idx, o_rk_last
    );

    modport slave (
        input  i_key_valid, i_w, i_rk_req, i_rk_dec,
        output o_key_ready, o_busy, o_rk_valid, o_rk, o_rk_idx, o_rk_last
    );
endinterface

// File: rtl/roundkey_seq.sv
// Round-key sequencer: waits for the key expansion to settle, snapshots the
// schedule, then streams round keys in encryption or decryption order.
module roundkey_seq #(
    parameter int WORD   = 32,
    parameter int NB     = 4,
    parameter int NK     = 4,
    parameter int NR     = 10,
    parameter int KE_LAT = NB * (NR + 1) - NK,
    parameter int IW     = $clog2(NR + 1)
) (
    input  logic           clk,
    input  logic           rst,
    roundkey_seq_if.slave  bus
);

    localparam int CW  = (KE_LAT > 1) ? $clog2(KE_LAT) : 1;
    localparam int RKW = WORD * NB;

    typedef enum logic [1:0] {IDLE, WAIT, READY, STREAM} state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            dec_q, dec_n;
    logic [IW-1:0]   idx_q, idx_n;
    logic            last_q, last_n;
    logic            capture;
    logic            ready_q, busy_q, valid_q;
    logic [RKW-1:0]  rk_q;
    logic [RKW-1:0]  rk_file [NR+1];

    // A key load restarts the settle wait from any state, aborting a stream.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dec_n   = dec_q;
        idx_n   = idx_q;
        last_n  = last_q;
        capture = 1'b0;
        if (bus.i_key_valid) begin
            state_n = WAIT;
            cnt_n   = CW'(KE_LAT - 1);
            last_n  = 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == '0) begin
                        capture = 1'b1;
                        state_n = READY;
                    end else begin
                        cnt_n = cnt_q - CW'(1);
                    end
                end
                READY: begin
                    if (bus.i_rk_req) begin
                        state_n = STREAM;
                        dec_n   = bus.i_rk_dec;
                        idx_n   = bus.i_rk_dec ? IW'(NR) : '0;
                        last_n  = 1'b0;
                    end
                end
                STREAM: begin
                    if (last_q) begin
                        state_n = READY;
                    end else if (dec_q) begin
                        idx_n  = idx_q - IW'(1);
                        last_n = (idx_q == IW'(1));
                    end else begin
                        idx_n  = idx_q + IW'(1);
                        last_n = (idx_q == IW'(NR - 1));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            dec_q   <= dec_n;
        end
    end

    // Status flags are derived from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            rk_q    <= '0;
        end else begin
            ready_q <= (state_n == READY) || (state_n == STREAM);
            busy_q  <= (state_n == WAIT) || (state_n == STREAM);
            valid_q <= (state_n == STREAM);
            idx_q   <= idx_n;
            last_q  <= last_n;
            if (state_n == STREAM) begin
                rk_q <= rk_file[idx_n];
            end
        end
    end

    // Lowest-numbered word of each round key lands in the MSBs.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k <= NR; k++) begin
                for (int j = 0; j < NB; j++) begin
                    rk_file[k][WORD*(NB-j)-1 -: WORD] <= bus.i_w[WORD*(NB*k+j) +: WORD];
                end
            end
        end
    end

    assign bus.o_key_ready = ready_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_rk_valid  = valid_q;
    assign bus.o_rk        = rk_q;
    assign bus.o_rk_idx    = idx_q;
    assign bus.o_rk_last   = last_q;

endmodule

// File: tb/tb_roundkey_seq.sv
// Bench for roundkey_seq: AES-128 and AES-256 instances against a
// behavioural schedule/stream model plus FIPS-197 literal round keys.
module tb_roundkey_seq;

    localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R14    = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    logic kv [2];
    logic req [2];
    logic dec [2];
    logic wgood [2] = '{1'b0, 1'b0};
    logic [1407:0] wa = '0;
    logic [1919:0] wb = '0;
    logic [31:0]   ws [2][60];

    logic          ordy [2];
    logic          obusy [2];
    logic          ov [2];
    logic [3:0]    oidx [2];
    logic [127:0]  ork [2];
    logic          olast [2];

    logic          m_loaded [2] = '{1'b0, 1'b0};
    logic          m_ready [2]  = '{1'b0, 1'b0};
    logic          m_busy [2]   = '{1'b0, 1'b0};
    logic          m_valid [2]  = '{1'b0, 1'b0};
    logic          m_last [2]   = '{1'b0, 1'b0};
    int            m_age [2]    = '{0, 0};
    int            m_idx [2]    = '{0, 0};
    logic [127:0]  m_rk [2]     = '{128'h0, 128'h0};
    int            m_plan [2][16];
    int            m_pos [2]    = '{0, 0};
    int            m_len [2]    = '{0, 0};

    roundkey_seq_if #(.WORD(32), .NB(4), .NR(10)) ifa ();
    roundkey_seq_if #(.WORD(32), .NB(4), .NR(14)) ifb ();

    roundkey_seq #(.WORD(32), .NB(4), .NK(4), .NR(10), .KE_LAT(40)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    roundkey_seq #(.WORD(32), .NB(4), .NK(8), .NR(14), .KE_LAT(52)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    assign ifa.i_key_valid = kv[0];
    assign ifa.i_rk_req    = req[0];
    assign ifa.i_rk_dec    = dec[0];
    assign ifa.i_w         = wgood[0] ? wa : ~wa;
    assign ifb.i_key_valid = kv[1];
    assign ifb.i_rk_req    = req[1];
    assign ifb.i_rk_dec    = dec[1];
    assign ifb.i_w         = wgood[1] ? wb : ~wb;

    assign ordy[0]  = ifa.o_key_ready;
    assign obusy[0] = ifa.o_busy;
    assign ov[0]    = ifa.o_rk_valid;
    assign oidx[0]  = ifa.o_rk_idx;
    assign ork[0]   = ifa.o_rk;
    assign olast[0] = ifa.o_rk_last;
    assign ordy[1]  = ifb.o_key_ready;
    assign obusy[1] = ifb.o_busy;
    assign ov[1]    = ifb.o_rk_valid;
    assign oidx[1]  = ifb.o_rk_idx;
    assign ork[1]   = ifb.o_rk;
    assign olast[1] = ifb.o_rk_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nr_of(input int d);
        return (d != 0) ? 14 : 10;
    endfunction

    function automatic int kel_of(input int d);
        return (d != 0) ? 52 : 40;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box built from its definition: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] rk_of(input int d, input int k);
        return {ws[d][4*k], ws[d][4*k+1], ws[d][4*k+2], ws[d][4*k+3]};
    endfunction

    task automatic setKey(input int d, input logic [255:0] key);
        int nk;
        int total;
        logic [31:0] t;
        logic [7:0]  rc;
        nk    = (d != 0) ? 8 : 4;
        total = 4 * (nr_of(d) + 1);
        rc    = 8'h01;
        for (int i = 0; i < nk; i++) ws[d][i] = key[32*(nk-1-i) +: 32];
        for (int i = nk; i < total; i++) begin
            t = ws[d][i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            ws[d][i] = ws[d][i-nk] ^ t;
        end
        if (d == 0) begin
            for (int i = 0; i < 44; i++) wa[32*i +: 32] = ws[0][i];
        end else begin
            for (int i = 0; i < 60; i++) wb[32*i +: 32] = ws[1][i];
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: a load starts a settle timer; an accepted request
    // enqueues the whole index sequence, one index presented per cycle.
    task automatic model_step(input int d);
        logic was_ready;
        if (!rst) begin
            m_loaded[d] = 1'b0; m_ready[d] = 1'b0; m_busy[d] = 1'b0;
            m_valid[d]  = 1'b0; m_last[d]  = 1'b0; m_idx[d]  = 0;
            m_rk[d]     = '0;   m_len[d]   = 0;    m_pos[d]  = 0;
        end else if (kv[d]) begin
            m_loaded[d] = 1'b1; m_age[d]  = 0;   m_ready[d] = 1'b0;
            m_valid[d]  = 1'b0; m_last[d] = 1'b0; m_busy[d] = 1'b1;
            m_len[d]    = 0;    m_pos[d]  = 0;
        end else begin
            was_ready = m_ready[d];
            if (m_loaded[d] && !m_ready[d]) begin
                m_age[d]++;
                if (m_age[d] >= kel_of(d)) m_ready[d] = 1'b1;
            end
            if (was_ready && !m_valid[d] && req[d]) begin
                m_len[d] = nr_of(d) + 1;
                m_pos[d] = 0;
                for (int k = 0; k <= nr_of(d); k++) m_plan[d][k] = dec[d] ? nr_of(d) - k : k;
            end
            if (m_pos[d] < m_len[d]) begin
                m_idx[d]  = m_plan[d][m_pos[d]];
                m_rk[d]   = rk_of(d, m_idx[d]);
                m_pos[d]++;
                m_valid[d] = 1'b1;
                m_last[d]  = (m_pos[d] == m_len[d]);
            end else begin
                m_valid[d] = 1'b0;
            end
            m_busy[d] = (m_loaded[d] && !m_ready[d]) || m_valid[d];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    // i_w shows the settled schedule only from the cycle the expansion would finish.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    checkOutput($sformatf("dut%0d_key_ready", d), 128'(ordy[d]),  128'(m_ready[d]));
                    checkOutput($sformatf("dut%0d_busy", d),      128'(obusy[d]), 128'(m_busy[d]));
                    checkOutput($sformatf("dut%0d_rk_valid", d),  128'(ov[d]),    128'(m_valid[d]));
                    checkOutput($sformatf("dut%0d_rk_idx", d),    128'(oidx[d]),  128'(m_idx[d]));
                    checkOutput($sformatf("dut%0d_rk", d),        ork[d],         m_rk[d]);
                    checkOutput($sformatf("dut%0d_rk_last", d),   128'(olast[d]), 128'(m_last[d]));
                end
            end
            for (int d = 0; d < 2; d++)
                wgood[d] = m_loaded[d] && (m_ready[d] || m_age[d] >= kel_of(d) - 1);
        end
    end

    task automatic applyStimulus(input int d, input logic kvv, input logic reqv, input logic decv);
        kv[d]  = kvv;
        req[d] = reqv;
        dec[d] = decv;
        @(negedge clk);
        kv[d]  = 1'b0;
        req[d] = 1'b0;
    endtask

    task automatic waitReady(input int d, input int exp_cycles, input int req_at);
        int n = 1;
        while (!ordy[d] && n < 200) begin
            req[d] = (n == req_at);
            @(negedge clk);
            n++;
        end
        req[d] = 1'b0;
        checkOutput($sformatf("dut%0d_ready_latency", d), 128'(n), 128'(exp_cycles));
    endtask

    task automatic runStream(input int d, input logic decv, input int nb,
                             input logic [127:0] first_rk, input int first_idx,
                             input logic [127:0] last_rk, input int last_idx, input int req_at);
        int n = 0;
        int last_count = 0;
        logic [127:0] k_rk = '0;
        int k_idx = -1;
        logic k_last = 1'b0;
        applyStimulus(d, 1'b0, 1'b1, decv);
        while (ov[d] && n < 40) begin
            if (n == 0) begin
                checkOutput("stream_first_rk", ork[d], first_rk);
                checkOutput("stream_first_idx", 128'(oidx[d]), 128'(first_idx));
            end
            k_rk   = ork[d];
            k_idx  = int'(oidx[d]);
            k_last = olast[d];
            if (olast[d]) last_count++;
            dec[d] = !decv;
            req[d] = (n == req_at) || (req_at >= 0 && n == nb - 1);
            @(negedge clk);
            n++;
            req[d] = 1'b0;
        end
        checkOutput("stream_beats", 128'(n), 128'(nb));
        checkOutput("stream_last_rk", k_rk, last_rk);
        checkOutput("stream_last_idx", 128'(k_idx), 128'(last_idx));
        checkOutput("stream_last_flag", 128'(k_last), 128'(1));
        checkOutput("stream_last_count", 128'(last_count), 128'(1));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            kv[d] = 1'b0; req[d] = 1'b0; dec[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_key_ready", 128'(ordy[0]), 128'(0));
        checkOutput("reset_busy", 128'(obusy[0]), 128'(0));
        checkOutput("reset_rk_valid", 128'(ov[0]), 128'(0));
        chk_en = 1'b1;
        rst    = 1'b1;

        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_req_ignored", 128'(ov[0]), 128'(0));

        setKey(1, K256);
        checkOutput("model_aes256_rk14", rk_of(1, 14), R14);
        setKey(0, {128'h0, K2});
        checkOutput("model_aes128_k2_rk10", rk_of(0, 10), K2_R10);
        setKey(0, {128'h0, K128});
        checkOutput("model_aes128_rk10", rk_of(0, 10), R10);

        $display("[TB] FIPS-197 AES-128 load, request during WAIT");
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("load_busy", 128'(obusy[0]), 128'(1));
        waitReady(0, 41, 10);
        runStream(0, 1'b0, 11, K128, 0, R10, 10, -1);
        runStream(0, 1'b1, 11, R10, 10, K128, 0, -1);
        runStream(0, 1'b0, 11, K128, 0, R10, 10, -1);

        $display("[TB] requests during stream and on final beat");
        runStream(0, 1'b0, 11, K128, 0, R10, 10, 3);
        runStream(0, 1'b1, 11, R10, 10, K128, 0, -1);

        $display("[TB] key load during beat 5");
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("abort_at_idx", 128'(oidx[0]), 128'(5));
        setKey(0, {128'h0, K2});
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_valid", 128'(ov[0]), 128'(0));
        checkOutput("abort_key_ready", 128'(ordy[0]), 128'(0));
        checkOutput("abort_busy", 128'(obusy[0]), 128'(1));
        waitReady(0, 41, -1);
        runStream(0, 1'b0, 11, K2, 0, K2_R10, 10, -1);

        $display("[TB] key load and request together");
        setKey(0, {128'h0, K128});
        applyStimulus(0, 1'b1, 1'b1, 1'b0);
        checkOutput("load_wins_valid", 128'(ov[0]), 128'(0));
        waitReady(0, 41, -1);
        runStream(0, 1'b1, 11, R10, 10, K128, 0, -1);

        $display("[TB] reset in the middle of WAIT");
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("midwait_reset_ready", 128'(ordy[0]), 128'(0));
        checkOutput("midwait_reset_busy", 128'(obusy[0]), 128'(0));
        checkOutput("midwait_reset_rk", ork[0], 128'h0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("post_reset_req_valid", 128'(ov[0]), 128'(0));
        checkOutput("post_reset_req_ready", 128'(ordy[0]), 128'(0));
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        waitReady(0, 41, -1);
        runStream(0, 1'b0, 11, K128, 0, R10, 10, -1);

        $display("[TB] FIPS-197 AES-256 instance");
        applyStimulus(1, 1'b1, 1'b0, 1'b0);
        waitReady(1, 53, -1);
        runStream(1, 1'b0, 15, K256[255:128], 0, R14, 14, -1);
        runStream(1, 1'b1, 15, R14, 14, K256[255:128], 0, -1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
